// File: rtl/ibex_branch_resolve.sv
// Branch prediction resolution: in-order record FIFO between fetch prediction and execute
// resolution, mispredict redirect FSM and saturating performance counters.
module ibex_branch_resolve #(
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pred_valid_i,
  input  logic                pred_taken_i,
  input  logic [31:0]         pred_pc_i,
  input  logic [31:0]         pred_fallthrough_i,
  output logic                pred_ready_o,
  input  logic                res_valid_i,
  input  logic                res_taken_i,
  input  logic [31:0]         res_target_i,
  output logic                res_ready_o,
  input  logic                flush_i,
  output logic                redirect_o,
  output logic [31:0]         redirect_pc_o,
  input  logic                redirect_ready_i,
  output logic [CntWidth-1:0] branch_cnt_o,
  output logic [CntWidth-1:0] mispredict_cnt_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam logic [IdxW:0]       PtrOne = {{IdxW{1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e              r_state, w_state_nxt;
  logic [IdxW:0]       r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic                r_taken  [Depth];
  logic [31:0]         r_target [Depth];
  logic [31:0]         r_fall   [Depth];
  logic [31:0]         r_redirect_pc, w_redirect_pc_nxt;
  logic [CntWidth-1:0] r_branch_cnt, r_mispredict_cnt;

  logic        w_full, w_empty, w_idle;
  logic        w_push, w_res, w_mispredict, w_res_misp;
  logic        w_head_taken;
  logic [31:0] w_head_target, w_head_fall, w_correct_pc;
  logic [IdxW-1:0] w_wr_idx, w_rd_idx;

  assign w_wr_idx = r_wr_ptr[IdxW-1:0];
  assign w_rd_idx = r_rd_ptr[IdxW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IdxW] != r_rd_ptr[IdxW]);
  assign w_idle   = (r_state == StIdle);

  assign pred_ready_o = w_idle && !w_full;
  assign res_ready_o  = w_idle && !w_empty;

  assign w_push = pred_valid_i && pred_ready_o && !flush_i;
  assign w_res  = res_valid_i && res_ready_o && !flush_i;

  assign w_head_taken  = r_taken[w_rd_idx];
  assign w_head_target = r_target[w_rd_idx];
  assign w_head_fall   = r_fall[w_rd_idx];

  assign w_mispredict = (res_taken_i != w_head_taken) ||
                        (res_taken_i && w_head_taken && (res_target_i != w_head_target));
  assign w_correct_pc = res_taken_i ? res_target_i : w_head_fall;
  assign w_res_misp   = w_res && w_mispredict;

  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_redirect_pc_nxt = r_redirect_pc;
    if (flush_i) begin
      // Controller redirect supersedes any pending one; all records are stale.
      w_state_nxt  = StIdle;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_res_misp) begin
            // Younger records and any same-cycle push are wrong-path.
            w_state_nxt       = StRedirect;
            w_redirect_pc_nxt = w_correct_pc;
            w_wr_ptr_nxt      = '0;
            w_rd_ptr_nxt      = '0;
          end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + PtrOne;
            if (w_res)  w_rd_ptr_nxt = r_rd_ptr + PtrOne;
          end
        end
        StRedirect: begin
          if (redirect_ready_i) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= StIdle;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

  // Record storage needs no reset: it is only read when the pointers say it is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_taken[w_wr_idx]  <= pred_taken_i;
      r_target[w_wr_idx] <= pred_pc_i;
      r_fall[w_wr_idx]   <= pred_fallthrough_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_res) begin
      if (!(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + CntOne;
      if (w_mispredict && !(&r_mispredict_cnt)) r_mispredict_cnt <= r_mispredict_cnt + CntOne;
    end
  end

  assign redirect_o       = (r_state == StRedirect);
  assign redirect_pc_o    = r_redirect_pc;
  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mispredict_cnt;

  // Execute must never resolve a branch that fetch did not predict.
  property p_res_without_record;
    @(posedge clk_i) disable iff (!rst_ni) !(res_valid_i && w_empty && w_idle && !flush_i);
  endproperty
  a_res_without_record: assert property (p_res_without_record);

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Scoreboard bench for ibex_branch_resolve: a queue-based reference of the record FIFO,
// expected redirect PCs queued at resolve time and compared when the redirect appears.
module tb_ibex_branch_resolve;

  localparam int unsigned Depth    = 2;
  localparam int unsigned CntWidth = 4;
  localparam int          CntMax   = 15;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                pred_valid_i, pred_taken_i;
  logic [31:0]         pred_pc_i, pred_fallthrough_i;
  logic                pred_ready_o;
  logic                res_valid_i, res_taken_i;
  logic [31:0]         res_target_i;
  logic                res_ready_o;
  logic                flush_i;
  logic                redirect_o;
  logic [31:0]         redirect_pc_o;
  logic                redirect_ready_i;
  logic [CntWidth-1:0] branch_cnt_o, mispredict_cnt_o;

  ibex_branch_resolve #(
    .Depth    (Depth),
    .CntWidth (CntWidth)
  ) u_dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .pred_valid_i       (pred_valid_i),
    .pred_taken_i       (pred_taken_i),
    .pred_pc_i          (pred_pc_i),
    .pred_fallthrough_i (pred_fallthrough_i),
    .pred_ready_o       (pred_ready_o),
    .res_valid_i        (res_valid_i),
    .res_taken_i        (res_taken_i),
    .res_target_i       (res_target_i),
    .res_ready_o        (res_ready_o),
    .flush_i            (flush_i),
    .redirect_o         (redirect_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i),
    .branch_cnt_o       (branch_cnt_o),
    .mispredict_cnt_o   (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fall;
  } rec_t;

  rec_t        m_q[$];
  logic [31:0] exp_q[$];
  int          m_branch, m_misp;
  bit          m_redir;
  int          n_checks, n_errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "/redirect"}, {31'b0, redirect_o}, {31'b0, m_redir});
    check_val({tag, "/pred_ready"}, {31'b0, pred_ready_o},
              {31'b0, (!m_redir && (m_q.size() < Depth))});
    check_val({tag, "/res_ready"}, {31'b0, res_ready_o},
              {31'b0, (!m_redir && (m_q.size() > 0))});
    check_val({tag, "/branch_cnt"}, 32'(branch_cnt_o), 32'(m_branch));
    check_val({tag, "/misp_cnt"}, 32'(mispredict_cnt_o), 32'(m_misp));
    if (m_redir) begin
      if (exp_q.size() > 0) check_val({tag, "/redirect_pc"}, redirect_pc_o, exp_q[0]);
      else check_val({tag, "/sb_empty"}, 32'd1, 32'd0);
    end
  endtask

  task automatic clear_inputs();
    pred_valid_i       = 1'b0;
    pred_taken_i       = 1'b0;
    pred_pc_i          = '0;
    pred_fallthrough_i = '0;
    res_valid_i        = 1'b0;
    res_taken_i        = 1'b0;
    res_target_i       = '0;
    flush_i            = 1'b0;
    redirect_ready_i   = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the reference model, then check all outputs.
  task automatic step(input logic pv, input logic pt, input logic [31:0] ppc,
                      input logic [31:0] pfall, input logic rv, input logic rt,
                      input logic [31:0] rtgt, input logic fl, input logic rr,
                      input string tag);
    bit   pr, rdy, do_push, do_res, misp, cur_redir;
    rec_t h, n;
    pred_valid_i = pv; pred_taken_i = pt; pred_pc_i = ppc; pred_fallthrough_i = pfall;
    res_valid_i = rv; res_taken_i = rt; res_target_i = rtgt;
    flush_i = fl; redirect_ready_i = rr;
    cur_redir = m_redir;
    pr  = !cur_redir && (m_q.size() < Depth);
    rdy = !cur_redir && (m_q.size() > 0);
    if (fl) begin
      m_q.delete();
      exp_q.delete();
      m_redir = 1'b0;
    end else begin
      do_push = pv && pr;
      do_res  = rv && rdy;
      misp    = 1'b0;
      if (do_res) begin
        h    = m_q.pop_front();
        misp = (rt != h.taken) || (rt && h.taken && (rtgt != h.target));
        if (m_branch < CntMax) m_branch++;
        if (misp) begin
          if (m_misp < CntMax) m_misp++;
          m_q.delete();
          m_redir = 1'b1;
          exp_q.push_back(rt ? rtgt : h.fall);
        end
      end
      if (do_push && !misp) begin
        n.taken = pt; n.target = ppc; n.fall = pfall;
        m_q.push_back(n);
      end
      if (cur_redir && rr) begin
        m_redir = 1'b0;
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk_i);
    #1;
    clear_inputs();
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    m_q.delete();
    exp_q.delete();
    m_redir  = 1'b0;
    m_branch = 0;
    m_misp   = 0;
    check_outputs(tag);
    check_val({tag, "/redirect_pc"}, redirect_pc_o, 32'h0);
    rst_ni = 1'b1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset("reset");

    // Correct prediction
    step(1, 1, 32'h100, 32'h204, 0, 0, 0, 0, 0, "ok_push");
    step(0, 0, 0, 0, 1, 1, 32'h100, 0, 0, "ok_res");
    check_val("ok_cnt_const", 32'(branch_cnt_o), 32'd1);

    // Direction mispredict with a held redirect
    step(1, 1, 32'h80, 32'h1004, 0, 0, 0, 0, 0, "dir_push");
    step(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, "dir_res");
    check_val("dir_pc_const", redirect_pc_o, 32'h1004);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, "dir_hold");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "dir_accept");
    check_val("dir_misp_const", 32'(mispredict_cnt_o), 32'd1);

    // Full FIFO, target mispredict discards the younger record
    step(1, 1, 32'h40, 32'h104, 0, 0, 0, 0, 0, "full_push0");
    step(1, 0, 32'h300, 32'h204, 0, 0, 0, 0, 0, "full_push1");
    step(1, 1, 32'h999, 32'h998, 0, 0, 0, 0, 0, "full_push2_blocked");
    step(0, 0, 0, 0, 1, 1, 32'h48, 0, 0, "full_res");
    check_val("full_pc_const", redirect_pc_o, 32'h48);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "full_accept");

    // Same-cycle push and correct resolve, then push with mispredicting resolve
    step(1, 1, 32'h500, 32'h504, 0, 0, 0, 0, 0, "pr_push");
    step(1, 0, 32'h0, 32'h600, 1, 1, 32'h500, 0, 0, "pr_both_ok");
    step(1, 1, 32'h700, 32'h704, 1, 1, 32'h610, 0, 1, "pr_both_misp");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, "pr_accept");

    // Flush while redirecting, with push/resolve attempts that must be dropped
    step(1, 1, 32'h800, 32'h804, 0, 0, 0, 0, 0, "fl_push");
    step(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, "fl_misp");
    step(1, 1, 32'h900, 32'h904, 1, 1, 32'h900, 1, 0, "fl_in_redirect");
    // Flush in idle with a non-empty FIFO and same-cycle push/resolve
    step(1, 0, 32'ha00, 32'ha04, 0, 0, 0, 0, 0, "fl_push2");
    step(1, 1, 32'hb00, 32'hb04, 1, 0, 32'h0, 1, 0, "fl_in_idle");

    // Reset in the middle of a redirect
    step(1, 0, 32'h0, 32'hc04, 0, 0, 0, 0, 0, "rst_push");
    step(0, 0, 0, 0, 1, 1, 32'hc80, 0, 0, "rst_misp");
    do_reset("rst_mid_redirect");

    // Saturation of both counters
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 32'h40, 32'h44, 0, 0, 0, 0, 0, "sat_push");
      step(0, 0, 0, 0, 1, 0, 32'h0, 0, 0, "sat_res");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, "sat_accept");
    end
    check_val("sat_branch_const", 32'(branch_cnt_o), 32'hf);
    check_val("sat_misp_const", 32'(mispredict_cnt_o), 32'hf);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_branch_resolve.md
# ibex_branch_resolve

Resolution end of static branch prediction. Holds a record for each predicted branch/jump from the time fetch predicts it until execute resolves it, in order. Compares the actual outcome with the prediction and issues a registered redirect to the correct PC on a mispredict. Sits between the IF-stage prediction output and the ID/EX branch unit, and keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- `Depth`, default 2: in-flight prediction records; power of two, ≥2.
- `CntWidth`, default 16: width of the performance counters.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; synchronous and active-low.
- `pred_valid_i` in 1: push a prediction record. Asserted for every branch/jump leaving fetch.
- `pred_taken_i` in 1: predicted taken.
- `pred_pc_i` in 32: predicted target (meaningful when taken).
- `pred_fallthrough_i` in 32: sequential successor PC (PC+2 or PC+4).
- `pred_ready_o` out 1: record accepted. High when the FIFO is not full and the state is IDLE.
- `res_valid_i` in 1: execute resolves the oldest branch/jump.
- `res_taken_i` in 1: actual direction.
- `res_target_i` in 32: actual target.
- `res_ready_o` out 1: high when the FIFO is not empty and the state is IDLE.
- `flush_i` in 1: controller flush (exception/debug). Highest priority.
- `redirect_o` out 1: mispredict redirect request.
- `redirect_pc_o` out 32: correct PC.
- `redirect_ready_i` in 1: fetch accepts the redirect.
- `branch_cnt_o` out CntWidth: resolved branches.
- `mispredict_cnt_o` out CntWidth: mispredicts.

## Operation
- Prediction records are held in an in-order FIFO of {taken, target, fallthrough}, with pointers of width log2(Depth) plus one wrap bit. Full means the indexes are equal and the wrap bits differ. Empty means the pointers are equal.
- A push happens when `pred_valid_i & pred_ready_o`.
- A resolve happens when `res_valid_i & res_ready_o`. It pops the head.
- `res_valid_i` while `res_ready_o` is 0 is ignored. An assertion flags `res_valid_i` with an empty FIFO while IDLE.
- Mispredict condition: `res_taken_i != head.taken`, or both taken and `res_target_i != head.target`.
- Correct PC: `res_target_i` if `res_taken_i`, else `head.fallthrough`.
- FSM states:
  - IDLE: normal operation. On a resolve with a mispredict, latch `redirect_pc_o`, clear the FIFO (younger records are wrong-path), and go to REDIRECT.
  - REDIRECT: `redirect_o` is 1, and pushes and resolves are blocked. On `redirect_ready_i`, return to IDLE.
- A resolve without a mispredict only pops. The state stays IDLE.
- Push and resolve in the same cycle:
  - Both are performed.
  - If the resolve mispredicts, the push is dropped (wrong-path) and the FIFO ends empty.
- `flush_i`:
  - Empties the FIFO, forces IDLE, and deasserts `redirect_o` the next cycle. A pending redirect is discarded because the controller's redirect supersedes it.
  - Any same-cycle push or resolve is dropped.
  - Counters are not updated that cycle.
- Counters:
  - `branch_cnt_o` increments by 1 on every resolve.
  - `mispredict_cnt_o` increments by 1 on every mispredicting resolve.
  - Both saturate at all-ones; there is no wrap.
- Reset (`rst_ni` low at a clock edge) applies in any state, including mid-redirect. It sets:
  - state IDLE and FIFO empty;
  - `redirect_o`=0 and `redirect_pc_o`=0;
  - both counters 0;
  - therefore `pred_ready_o`=1 and `res_ready_o`=0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Push-to-resolve: a record pushed in cycle N is resolvable in cycle N+1, when `res_ready_o` goes to 1. There is no bypass.
- Mispredict resolve in cycle N:
  - `redirect_o`=1 and `redirect_pc_o` are valid from N+1.
  - They are held stable until the cycle `redirect_ready_i`=1 (inclusive).
  - `redirect_o`=0 the following cycle.
- `redirect_ready_i` in the first REDIRECT cycle gives a one-cycle redirect pulse.
- Counters update on the clock edge ending the resolve cycle.
- `pred_ready_o` does not look ahead to a same-cycle pop. When full, a push waits one cycle after a pop.

## Test plan
- Reset then idle: `pred_ready_o`=1, `res_ready_o`=0, `redirect_o`=0, both counters 0.
- Correct prediction:
  - Push {taken=1, target=0x100, fallthrough=0x204}, then resolve {taken=1, target=0x100}.
  - Expect no redirect, `branch_cnt_o`=1, `mispredict_cnt_o`=0.
- Direction mispredict:
  - Push {taken=1, target=0x80, fallthrough=0x1004}, then resolve taken=0.
  - Expect `redirect_o`=1 and `redirect_pc_o`=0x1004 the next cycle.
  - Hold `redirect_ready_i`=0 for 3 cycles: the redirect stays stable.
  - Assert `redirect_ready_i`=1: `redirect_o`=0 the cycle after, `mispredict_cnt_o`=1.
- Full FIFO with younger entries:
  - Depth=2, push 2 records; the third push sees `pred_ready_o`=0.
  - Resolve the head as a target mispredict (predicted 0x40, actual 0x48): `redirect_pc_o`=0x48.
  - The FIFO empties, so `res_ready_o`=0 after the redirect is accepted.
- Flush precedence:
  - While in REDIRECT, assert `flush_i` together with `redirect_ready_i`=0.
  - Expect `redirect_o`=0 next cycle and the FIFO empty.
  - Same-cycle push and resolve are dropped, and counters are unchanged.
- Saturation: with CntWidth=4, resolve 20 mispredicting branches. Both counters read 0xF; there is no wrap.
